// File: rtl/frame_scheduler.sv
// Paces the renderer to display vblank, double-buffers its framebuffer writes and handles game-over restart.
// Write steering is 1 cycle; swap/ce/rst are registered. There is no backpressure: a frame not done when due is counted as an overrun.
module frame_scheduler #(
  parameter int ADDR_WIDTH     = 19,
  parameter int FRAME_DIVIDER  = 2,
  parameter int RESTART_FRAMES = 60
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_vsync_start,
  input  logic                  i_btn_raw,
  input  logic                  i_render_done,
  input  logic                  i_render_lose,
  input  logic                  i_render_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_render_wr_addr,
  input  logic                  i_render_wr_data,
  output logic                  o_render_ce,
  output logic                  o_render_rst,
  output logic                  o_render_swap,
  output logic                  o_btn,
  output logic                  o_fb_wr_en,
  output logic [ADDR_WIDTH:0]   o_fb_wr_addr,
  output logic                  o_fb_wr_data,
  output logic                  o_disp_buf,
  output logic [15:0]           o_frame_count,
  output logic [7:0]            o_overrun_count
);

  localparam int VW = (FRAME_DIVIDER > 1) ? $clog2(FRAME_DIVIDER) : 1;
  localparam int LW = $clog2(RESTART_FRAMES + 1);
  localparam logic [VW-1:0] VMAX = VW'(FRAME_DIVIDER - 1);
  localparam logic [LW-1:0] LMAX = LW'(RESTART_FRAMES);

  typedef enum logic [1:0] {S_RESET, S_RENDER, S_WAIT_VSYNC} state_t;

  state_t                r_state;
  logic [1:0]            r_rst_cnt;
  logic [VW-1:0]         r_vsync_cnt;
  logic [LW-1:0]         r_lose_cnt;
  logic                  r_btn_meta, r_btn_s;
  logic                  r_render_ce, r_render_rst, r_render_swap, r_btn, r_disp_buf;
  logic                  r_fb_wr_en, r_fb_wr_data;
  logic [ADDR_WIDTH:0]   r_fb_wr_addr;
  logic [15:0]           r_frame_count;
  logic [7:0]            r_overrun_count;

  logic w_due, w_swap;
  assign w_due  = i_vsync_start && (r_vsync_cnt == VMAX);
  assign w_swap = w_due && ((r_state == S_WAIT_VSYNC) || (r_state == S_RENDER && i_render_done));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_RESET;
      r_rst_cnt       <= '0;
      r_vsync_cnt     <= '0;
      r_lose_cnt      <= '0;
      r_btn_meta      <= 1'b0;
      r_btn_s         <= 1'b0;
      r_render_ce     <= 1'b0;
      r_render_rst    <= 1'b1;
      r_render_swap   <= 1'b0;
      r_btn           <= 1'b0;
      r_disp_buf      <= 1'b0;
      r_fb_wr_en      <= 1'b0;
      r_fb_wr_addr    <= '0;
      r_fb_wr_data    <= 1'b0;
      r_frame_count   <= '0;
      r_overrun_count <= '0;
    end else begin
      r_btn_meta    <= i_btn_raw;
      r_btn_s       <= r_btn_meta;
      r_fb_wr_en    <= i_render_wr_en & r_render_ce;
      r_fb_wr_addr  <= {~r_disp_buf, i_render_wr_addr};
      r_fb_wr_data  <= i_render_wr_data;
      r_render_swap <= 1'b0;

      // vblanks are counted in every state, including RESET
      if (i_vsync_start && r_vsync_cnt != VMAX)
        r_vsync_cnt <= r_vsync_cnt + 1'b1;

      case (r_state)
        S_RESET: begin
          r_render_rst <= 1'b1;
          r_render_ce  <= 1'b0;
          if (r_rst_cnt == 2'd1) begin
            r_state      <= S_RENDER;
            r_render_rst <= 1'b0;
            r_render_ce  <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt + 2'd1;
          end
        end
        S_RENDER: begin
          if (w_due && !i_render_done) begin
            if (r_overrun_count != 8'hFF)
              r_overrun_count <= r_overrun_count + 8'd1;
          end else if (i_render_done && !w_due) begin
            r_state <= S_WAIT_VSYNC;
          end
        end
        default: ;
      endcase

      if (w_swap) begin
        r_render_swap <= 1'b1;
        r_disp_buf    <= ~r_disp_buf;
        r_btn         <= r_btn_s;
        r_vsync_cnt   <= '0;
        r_state       <= S_RENDER;
        r_frame_count <= r_frame_count + 16'd1;
        if (!i_render_lose) begin
          r_lose_cnt <= '0;
        end else if (r_lose_cnt < LMAX) begin
          r_lose_cnt <= r_lose_cnt + 1'b1;
        end else if (r_btn_s) begin
          // game over held long enough and button pressed: restart the renderer
          r_state       <= S_RESET;
          r_frame_count <= '0;
          r_lose_cnt    <= '0;
          r_rst_cnt     <= '0;
          r_render_rst  <= 1'b1;
          r_render_ce   <= 1'b0;
        end
      end
    end
  end

  assign o_render_ce     = r_render_ce;
  assign o_render_rst    = r_render_rst;
  assign o_render_swap   = r_render_swap;
  assign o_btn           = r_btn;
  assign o_fb_wr_en      = r_fb_wr_en;
  assign o_fb_wr_addr    = r_fb_wr_addr;
  assign o_fb_wr_data    = r_fb_wr_data;
  assign o_disp_buf      = r_disp_buf;
  assign o_frame_count   = r_frame_count;
  assign o_overrun_count = r_overrun_count;

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Sequences frame_renderer against display timing and owns the double-buffered framebuffer write port.
- Gates the renderer with ce and pulses its swap input on a vertical-blank boundary.
- Steers renderer writes into the back buffer, and latches the button once per game frame.
- After a loss, holds the game over screen and restarts the renderer on a button press.

Parameters:
- ADDR_WIDTH, 19: width of renderer wr_addr (one buffer).
- FRAME_DIVIDER, 2: display frames per game frame; must be >= 1.
- RESTART_FRAMES, 60: minimum swaps spent in lose before a restart is accepted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- vsync_start  in  1  one-cycle pulse at start of vertical blank.
- btn_raw  in  1  asynchronous push-button.
- render_done  in  1  level, high while the renderer is in DONE.
- render_lose  in  1  renderer lose flag.
- render_wr_en  in  1  renderer write enable.
- render_wr_addr  in  ADDR_WIDTH  renderer write address.
- render_wr_data  in  1  renderer write data.
- render_ce  out  1  renderer clock enable.
- render_rst  out  1  renderer synchronous reset, active-high.
- render_swap  out  1  one-cycle swap pulse to the renderer.
- btn  out  1  per-frame latched button to the renderer.
- fb_wr_en  out  1  framebuffer write enable.
- fb_wr_addr  out  ADDR_WIDTH+1  {back_buf, render_wr_addr}.
- fb_wr_data  out  1  framebuffer write data.
- disp_buf  out  1  buffer currently scanned out.
- frame_count  out  16  swaps since the last restart, wrapping.
- overrun_count  out  8  late frames, saturating at 255.

Behaviour:
- Reset (async, rst_n=0):
  - state=RESET, rst_cnt=0, render_rst=1.
  - render_ce=0, render_swap=0, btn=0, disp_buf=0 (back_buf = ~disp_buf = 1).
  - fb_wr_* = 0, frame_count=0, overrun_count=0, vsync_cnt=0, lose_cnt=0, sync flops=0.
- Button input: btn_raw passes through a 2-flop synchronizer to btn_s. btn_s is sampled into btn only on the swap cycle; btn is stable for a whole game frame.
- vsync_cnt:
  - Increments on vsync_start, saturating at FRAME_DIVIDER-1.
  - Cleared on the swap cycle.
  - "Due" means vsync_start=1 and vsync_cnt==FRAME_DIVIDER-1.
- Write steering (registered, 1-cycle latency):
  - fb_wr_en <= render_wr_en & render_ce.
  - fb_wr_addr <= {~disp_buf, render_wr_addr}.
  - fb_wr_data <= render_wr_data.
  - Writes never target disp_buf.
- FSM:
  - RESET:
    - render_rst=1, render_ce=0.
    - rst_cnt counts 2 cycles, then go to RENDER with render_rst=0 and render_ce=1.
  - RENDER:
    - render_ce=1.
    - Due and render_done=1 in the same cycle: swap this cycle (below); the frame is not late.
    - Due and render_done=0: overrun_count++ (saturating), stay in RENDER.
    - render_done=1 without due: go to WAIT_VSYNC.
  - WAIT_VSYNC:
    - render_ce=1; the renderer idles in DONE.
    - On due: swap.
  - Swap cycle (registered, 1 cycle):
    - render_swap=1, disp_buf toggles, btn<=btn_s, frame_count++, vsync_cnt<=0.
    - Next state:
      - render_lose=0: RENDER, lose_cnt=0.
      - render_lose=1 and lose_cnt<RESTART_FRAMES: RENDER, lose_cnt++ (saturating at RESTART_FRAMES).
      - render_lose=1, lose_cnt==RESTART_FRAMES, btn_s=1: RESET, frame_count<=0, lose_cnt<=0, rst_cnt<=0.
    - overrun_count persists across restarts.
  - render_swap is 0 in every cycle other than the swap cycle.
- Boundary conditions:
  - FRAME_DIVIDER=1: every vsync_start is due.
  - frame_count wraps 0xFFFF -> 0.
  - Reset asserted mid-write: fb_wr_en drops to 0 asynchronously.
  - A vsync_start in RESET is counted, and can make the first frame late.

Test Plan:
- Reset release, FRAME_DIVIDER=2 -> render_rst high for exactly 2 cycles, then render_ce=1; disp_buf=0; first fb_wr_addr MSB=1.
- Renderer asserts render_done 10 cycles after start; vsync_start at display frames 1 and 2 -> single render_swap pulse on the 2nd vsync; disp_buf=1; frame_count=1; next writes have MSB=0.
- render_done rises in the same cycle as a due vsync_start -> swap in that cycle; overrun_count stays 0.
- render_done withheld across 3 due vsyncs -> overrun_count=3, no swap; done then raised -> swap on the next due vsync.
- btn_raw toggles mid-frame -> btn changes only on the swap cycle, after the 2-cycle sync delay.
- render_lose=1, RESTART_FRAMES=4, btn_s=1 throughout -> 4 normal swaps, then RESET on the 5th swap: render_rst pulse, frame_count=0, overrun_count unchanged.
